// File: rtl/dmem_access_unit.sv
// dmem_access_unit: data-memory access stage between the datapath and a
// variable-latency valid/ready data bus. Holds the core in Stall while an
// access is in flight, returns load data and reports bus errors/timeouts.
// Optional build macro: DMEM_MISALIGN_CHECK_EN (faults misaligned accesses
// without issuing a bus request; otherwise the low address bits are cleared).
//
// state | meaning
// IDLE  | waiting for MemRead/MemWrite, captures address/data/we
// REQ   | bus_req_valid high until the bus accepts
// RSP   | waiting for bus_rsp_valid, timeout counter running
// DONE  | one-cycle retire slot, ReadData/MemFault presented
module dmem_access_unit #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [AW-1:0] ALUResult,
    input  logic [31:0]   WriteData,
    output logic [31:0]   ReadData,
    output logic          Stall,
    output logic          MemFault,
    output logic          bus_req_valid,
    input  logic          bus_req_ready,
    output logic [AW-1:0] bus_addr,
    output logic          bus_we,
    output logic [31:0]   bus_wdata,
    input  logic          bus_rsp_valid,
    input  logic [31:0]   bus_rdata,
    input  logic          bus_rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          we_q, we_d;
    logic          fault_q, fault_d;
    logic          access_req;
    logic          misaligned;
    logic [AW-1:0] addr_in;

    assign access_req = MemRead | MemWrite;

`ifdef DMEM_MISALIGN_CHECK_EN
    // Misaligned accesses never reach the bus; the full address is kept.
    assign misaligned = (ALUResult[1:0] != 2'b00);
    assign addr_in    = ALUResult;
`else
    // Without the check every access is treated as word-aligned.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^ALUResult[1:0];
    assign misaligned      = 1'b0;
    assign addr_in         = {ALUResult[AW-1:2], 2'b00};
`endif

    // State and capture registers; reset drops the access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            fault_q <= fault_d;
        end
    end

    // Next-state and capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (access_req) begin
                    addr_d  = addr_in;
                    wdata_d = WriteData;
                    we_d    = MemWrite;  // store wins when both are set
                    cnt_d   = '0;
                    if (misaligned) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = REQ;
                        fault_d = 1'b0;
                    end
                end
            end
            REQ: begin
                if (bus_req_ready) begin
                    state_d = RSP;
                    cnt_d   = '0;
                end
            end
            RSP: begin
                if (bus_rsp_valid) begin
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    fault_d = bus_rsp_err;
                    state_d = DONE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    fault_d = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; Stall is also forced low while in reset.
    always_comb begin
        bus_req_valid = (state_q == REQ);
        Stall         = reset & (((state_q == IDLE) & access_req) |
                                 (state_q == REQ) | (state_q == RSP));
        MemFault      = (state_q == DONE) & fault_q;
    end

    assign bus_addr  = addr_q;
    assign bus_we    = we_q;
    assign bus_wdata = wdata_q;
    assign ReadData  = rdata_q;

endmodule
